// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared definitions for the skin-segmentation threshold
//               controller: threshold addresses, FSM encoding, default
//               threshold values and the mask-pixel counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Host-visible threshold addresses
    localparam logic [1:0] THR_TA = 2'd0;  // Cb lower bound
    localparam logic [1:0] THR_TB = 2'd1;  // Cb upper bound
    localparam logic [1:0] THR_TC = 2'd2;  // Cr lower bound
    localparam logic [1:0] THR_TD = 2'd3;  // Cr upper bound

    // Commit FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } seg_state_e;

    // Default threshold set
    localparam logic [7:0] C_TA_DEF = 8'd90;
    localparam logic [7:0] C_TB_DEF = 8'd140;
    localparam logic [7:0] C_TC_DEF = 8'd90;
    localparam logic [7:0] C_TD_DEF = 8'd126;

    // Width of the per-frame mask pixel counter
    localparam int MASK_CNT_W = 20;

endpackage
`default_nettype wire

// File: rtl/seg_thr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_thr_ctrl_if
// Description : Host configuration channel for seg_thr_ctrl. Threshold writes
//               use a valid/ready handshake; cfg_apply asks the controller to
//               commit the shadow set at the next frame boundary.
//   Signals   : cfg_valid  - write request
//               cfg_ready  - controller accepts the write this cycle
//               cfg_addr   - threshold select (0=Ta 1=Tb 2=Tc 3=Td)
//               cfg_data   - threshold value
//               cfg_apply  - commit request
//   Modports  : master (host), slave (controller)
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_thr_ctrl_if;

    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_apply;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        output cfg_apply,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        input  cfg_apply,
        output cfg_ready
    );

endinterface
`default_nettype wire

// File: rtl/seg_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : seg_edge_det
// Description : Rising-edge detector. The input is registered once and the
//               edge flag is the current input ANDed with the inverted
//               registered copy, so a rise is reported in the same cycle the
//               input goes high.
//   Ports     : clk   - clock
//               rst   - synchronous active-high reset (clears the history)
//               i_ce  - clock enable; history holds while low
//               i_din - level input
//               o_rise- rising-edge flag
// Revision    : 1.0 - initial release
// ============================================================================
module seg_edge_det (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_ce,
    input  wire logic i_din,
    output logic      o_rise
);

    logic r_din_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_d <= 1'b0;
        end else if (i_ce) begin
            r_din_d <= i_din;
        end
    end

    assign o_rise = i_din & ~r_din_d;

endmodule
`default_nettype wire

// File: rtl/seg_thr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_thr_ctrl
// Description : Frame-synchronous threshold controller. Host writes land in
//               shadow registers; after cfg_apply the whole shadow set is
//               copied to the active thresholds on the next rising edge of
//               vsync, so a frame never sees a mixed set. Also counts frames
//               and, optionally, mask pixels per frame.
//   Ports     : clk, rst        - clock, synchronous active-high reset
//               ce              - clock enable, all state holds when low
//               vsync, de, mask - pipeline timing and threshold result
//               cfg             - host channel (seg_thr_ctrl_if.slave)
//               ta..td          - active thresholds
//               commit          - one-cycle pulse, active set updated
//               pending         - shadow set waiting for a frame boundary
//               frame_cnt       - frames seen since reset (wraps)
//               mask_cnt        - mask pixels in the last complete frame
//               mask_cnt_vld    - one-cycle pulse, mask_cnt updated
//   Options   : SEG_THR_CTRL_STATS_EN - builds the mask pixel counter;
//               without it mask_cnt and mask_cnt_vld are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_thr_ctrl
    import seg_pkg::*;
#(
    parameter logic [7:0] TA_INIT = 8'd90,
    parameter logic [7:0] TB_INIT = 8'd140,
    parameter logic [7:0] TC_INIT = 8'd90,
    parameter logic [7:0] TD_INIT = 8'd126,
    parameter int         FCNT_W  = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  ce,
    input  wire logic                  vsync,
    input  wire logic                  de,
    input  wire logic                  mask,
    seg_thr_ctrl_if.slave              cfg,
    output logic [7:0]                 ta,
    output logic [7:0]                 tb,
    output logic [7:0]                 tc,
    output logic [7:0]                 td,
    output logic                       commit,
    output logic                       pending,
    output logic [FCNT_W-1:0]          frame_cnt,
    output logic [MASK_CNT_W-1:0]      mask_cnt,
    output logic                       mask_cnt_vld
);

    localparam logic [3:0][7:0] C_INIT_SET = {TD_INIT, TC_INIT, TB_INIT, TA_INIT};

    seg_state_e       r_state;
    seg_state_e       w_state_nxt;
    logic [3:0][7:0]  r_shadow;
    logic [3:0][7:0]  w_shadow_nxt;
    logic [3:0][7:0]  r_active;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic             w_fb;
    logic             w_ready;
    logic             w_wr;
    logic             w_load;

    // ------------------------------------------------------------------
    // Frame boundary: rising edge of vsync
    // ------------------------------------------------------------------
    seg_edge_det u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .i_ce   (ce),
        .i_din  (vsync),
        .o_rise (w_fb)
    );

    // ------------------------------------------------------------------
    // Next-state / handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = 1'b1;
        w_load       = 1'b0;
        commit       = 1'b0;
        pending      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // An apply coinciding with a boundary only arms; the commit
                // waits for the following boundary.
                if (cfg.cfg_apply) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                pending = 1'b1;
                if (w_fb) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_ready     = 1'b0;
                commit      = 1'b1;
                pending     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_wr = cfg.cfg_valid & w_ready;

        // The merged shadow feeds the active load, so a write in the same
        // cycle as the boundary is part of the committed set.
        w_shadow_nxt = r_shadow;
        if (w_wr) begin
            w_shadow_nxt[cfg.cfg_addr] = cfg.cfg_data;
        end
    end

    // ------------------------------------------------------------------
    // State, shadow, active set and frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shadow    <= C_INIT_SET;
            r_active    <= C_INIT_SET;
            r_frame_cnt <= '0;
        end else if (ce) begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            if (w_load) begin
                r_active <= w_shadow_nxt;
            end
            if (w_fb) begin
                r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            end
        end
    end

    assign cfg.cfg_ready = w_ready;
    assign ta            = r_active[THR_TA];
    assign tb            = r_active[THR_TB];
    assign tc            = r_active[THR_TC];
    assign td            = r_active[THR_TD];
    assign frame_cnt     = r_frame_cnt;

    // ------------------------------------------------------------------
    // Optional per-frame mask pixel statistics
    // ------------------------------------------------------------------
`ifdef SEG_THR_CTRL_STATS_EN
    logic [MASK_CNT_W-1:0] r_pix_cnt;
    logic [MASK_CNT_W-1:0] r_mask_cnt;
    logic                  r_mask_vld;
    logic                  w_hit;

    assign w_hit = de & mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt  <= '0;
            r_mask_cnt <= '0;
            r_mask_vld <= 1'b0;
        end else if (ce) begin
            r_mask_vld <= w_fb;
            if (w_fb) begin
                r_mask_cnt <= r_pix_cnt;
                // A hit on the boundary cycle belongs to the new frame.
                r_pix_cnt  <= w_hit ? MASK_CNT_W'(1) : '0;
            end else if (w_hit && (r_pix_cnt != '1)) begin
                r_pix_cnt  <= r_pix_cnt + MASK_CNT_W'(1);
            end
        end
    end

    assign mask_cnt     = r_mask_cnt;
    assign mask_cnt_vld = r_mask_vld;
`else
    logic w_unused_stats;

    assign w_unused_stats = &{1'b0, de, mask};
    assign mask_cnt       = '0;
    assign mask_cnt_vld   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_thr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_thr_ctrl
// Description : Directed self-checking bench for seg_thr_ctrl. Inputs change
//               1 time unit after each rising clock edge; outputs are
//               sampled at the same point, reflecting the preceding edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_thr_ctrl;
    import seg_pkg::*;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        vsync;
    logic        de;
    logic        mask;
    logic [7:0]  ta, tb, tc, td;
    logic        commit;
    logic        pending;
    logic [15:0] frame_cnt;
    logic [MASK_CNT_W-1:0] mask_cnt;
    logic        mask_cnt_vld;

    int checks;
    int failures;

    seg_thr_ctrl_if cfg_if ();

    seg_thr_ctrl #(
        .TA_INIT (C_TA_DEF),
        .TB_INIT (C_TB_DEF),
        .TC_INIT (C_TC_DEF),
        .TD_INIT (C_TD_DEF),
        .FCNT_W  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .vsync        (vsync),
        .de           (de),
        .mask         (mask),
        .cfg          (cfg_if),
        .ta           (ta),
        .tb           (tb),
        .tc           (tc),
        .td           (td),
        .commit       (commit),
        .pending      (pending),
        .frame_cnt    (frame_cnt),
        .mask_cnt     (mask_cnt),
        .mask_cnt_vld (mask_cnt_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_thr(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [7:0] ec, input logic [7:0] ed);
        chk({tag, "_ta"}, 32'(ta), 32'(ea));
        chk({tag, "_tb"}, 32'(tb), 32'(eb));
        chk({tag, "_tc"}, 32'(tc), 32'(ec));
        chk({tag, "_td"}, 32'(td), 32'(ed));
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = a;
        cfg_if.cfg_data  = d;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic apply();
        cfg_if.cfg_apply = 1'b1;
        tick();
        cfg_if.cfg_apply = 1'b0;
    endtask

    // Rising vsync edge, then low for two cycles; checks commit on the
    // cycle after the rise.
    task automatic vs_pulse(input string tag, input logic exp_commit);
        vsync = 1'b1;
        tick();
        chk({tag, "_commit"}, 32'(commit), 32'(exp_commit));
        vsync = 1'b0;
        tick();
        chk({tag, "_commit_off"}, 32'(commit), 32'd0);
        tick();
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        ce               = 1'b1;
        vsync            = 1'b0;
        de               = 1'b0;
        mask             = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_addr  = 2'd0;
        cfg_if.cfg_data  = 8'd0;
        cfg_if.cfg_apply = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---- reset state ----
        chk_thr("rst", 8'd90, 8'd140, 8'd90, 8'd126);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("rst_mcnt", 32'(mask_cnt), 32'd0);
        chk("rst_mvld", 32'(mask_cnt_vld), 32'd0);

        // ---- 1: frames counted, no commit without apply ----
        vs_pulse("t1a", 1'b0);
        chk("t1_fcnt1", 32'(frame_cnt), 32'd1);
        vs_pulse("t1b", 1'b0);
        chk("t1_fcnt2", 32'(frame_cnt), 32'd2);
        vs_pulse("t1c", 1'b0);
        chk("t1_fcnt3", 32'(frame_cnt), 32'd3);
        chk_thr("t1", 8'd90, 8'd140, 8'd90, 8'd126);

        // ---- 2: shadow writes committed only at the boundary ----
        wr(THR_TA, 8'd100);
        wr(THR_TD, 8'd130);
        chk_thr("t2_shadow", 8'd90, 8'd140, 8'd90, 8'd126);
        apply();
        chk("t2_pending", 32'(pending), 32'd1);
        tick();
        tick();
        chk_thr("t2_wait", 8'd90, 8'd140, 8'd90, 8'd126);
        chk("t2_commit_wait", 32'(commit), 32'd0);
        vsync = 1'b1;
        tick();
        chk("t2_commit", 32'(commit), 32'd1);
        chk("t2_pending_c", 32'(pending), 32'd1);
        chk("t2_ready_c", 32'(cfg_if.cfg_ready), 32'd0);
        chk_thr("t2_new", 8'd100, 8'd140, 8'd90, 8'd130);
        vsync = 1'b0;
        tick();
        chk("t2_commit_end", 32'(commit), 32'd0);
        chk("t2_pending_end", 32'(pending), 32'd0);
        chk("t2_ready_end", 32'(cfg_if.cfg_ready), 32'd1);
        chk("t2_fcnt", 32'(frame_cnt), 32'd4);
        tick();

        // ---- 3: write coincident with the boundary is included ----
        apply();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = THR_TB;
        cfg_if.cfg_data  = 8'd150;
        vsync            = 1'b1;
        tick();
        cfg_if.cfg_valid = 1'b0;
        chk("t3_commit", 32'(commit), 32'd1);
        chk_thr("t3", 8'd100, 8'd150, 8'd90, 8'd130);
        vsync = 1'b0;
        tick();
        tick();

        // ---- 4: apply on the boundary from IDLE waits one frame ----
        wr(THR_TC, 8'd77);
        cfg_if.cfg_apply = 1'b1;
        vsync            = 1'b1;
        tick();
        cfg_if.cfg_apply = 1'b0;
        chk("t4_commit_early", 32'(commit), 32'd0);
        chk("t4_pending", 32'(pending), 32'd1);
        chk("t4_tc_hold", 32'(tc), 32'd90);
        vsync = 1'b0;
        tick();
        tick();
        vs_pulse("t4_next", 1'b1);
        chk_thr("t4", 8'd100, 8'd150, 8'd77, 8'd130);
        chk("t4_fcnt", 32'(frame_cnt), 32'd7);

        // ---- 5: reset while ARMED discards the pending set ----
        apply();
        wr(THR_TC, 8'd70);
        chk("t5_pending", 32'(pending), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_pending_rst", 32'(pending), 32'd0);
        chk("t5_fcnt_rst", 32'(frame_cnt), 32'd0);
        tick();
        vs_pulse("t5", 1'b0);
        chk_thr("t5", 8'd90, 8'd140, 8'd90, 8'd126);
        chk("t5_fcnt", 32'(frame_cnt), 32'd1);

        // ---- clock enable low: boundary ignored ----
        ce    = 1'b0;
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        tick();
        ce = 1'b1;
        tick();
        chk("ce_fcnt_hold", 32'(frame_cnt), 32'd1);

        // ---- 6: 64x64 frame with 500 mask pixels ----
        for (int i = 0; i < 4096; i++) begin
            de   = 1'b1;
            mask = (i < 500);
            tick();
        end
        de    = 1'b0;
        mask  = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
`ifdef SEG_THR_CTRL_STATS_EN
        chk("t6_mcnt", 32'(mask_cnt), 32'd500);
        chk("t6_mvld", 32'(mask_cnt_vld), 32'd1);
`else
        chk("t6_mcnt", 32'(mask_cnt), 32'd0);
        chk("t6_mvld", 32'(mask_cnt_vld), 32'd0);
`endif
        vsync = 1'b0;
        tick();
        chk("t6_mvld_off", 32'(mask_cnt_vld), 32'd0);
        chk("t6_fcnt", 32'(frame_cnt), 32'd2);
        tick();

        // ---- Ta > Tb passes through unchanged ----
        wr(THR_TA, 8'd200);
        wr(THR_TB, 8'd10);
        apply();
        vs_pulse("inv", 1'b1);
        chk_thr("inv", 8'd200, 8'd10, 8'd90, 8'd126);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_thr_ctrl.md
Name: seg_thr_ctrl

Overview:
Frame-synchronous configuration controller for the skin-segmentation pipeline (RGB->YCbCr conversion, YCbCr thresholding, centroid).
- Accepts threshold writes from a host-side requester over a valid/ready handshake and holds them in shadow registers.
- Commits all four thresholds atomically at the next frame boundary, so no frame is segmented with a mixed threshold set.
- Counts frames and reports commit events.

Parameters:
TA_INIT, 8'd90, reset value of Ta (Cb lower bound)
TB_INIT, 8'd140, reset value of Tb (Cb upper bound)
TC_INIT, 8'd90, reset value of Tc (Cr lower bound)
TD_INIT, 8'd126, reset value of Td (Cr upper bound)
FCNT_W, 16, frame counter width

Ports:
clk  in  1  pixel clock (rx_pclk domain)
rst  in  1  synchronous reset, active-high
ce  in  1  clock enable; when low, all state holds
vsync  in  1  pipeline vsync (active-high), taken from conversion output
de  in  1  pipeline data enable
mask  in  1  thresholding result bit (binary == 8'hFF)
cfg_valid  in  1  host write request
cfg_ready  out  1  controller accepts write this cycle
cfg_addr  in  2  0=Ta, 1=Tb, 2=Tc, 3=Td
cfg_data  in  8  threshold value
cfg_apply  in  1  host request to commit shadow set (sampled with cfg_valid&cfg_ready, or alone)
ta, tb, tc, td  out  8 each  active thresholds to the thresholding block
commit  out  1  one-cycle pulse when active set updated
pending  out  1  shadow set awaiting frame boundary
frame_cnt  out  FCNT_W  frames seen since reset
mask_cnt  out  20  mask pixels in last complete frame (feature-dependent)
mask_cnt_vld  out  1  one-cycle pulse, mask_cnt updated

Behaviour:
- Reset (rst=1 at clk edge): ta..td = *_INIT, shadows = *_INIT, state IDLE, cfg_ready=1, commit=0, pending=0, frame_cnt=0, mask_cnt=0, mask_cnt_vld=0, vsync_d=0.
- All updates gated by ce; rst overrides ce.
- Frame boundary: fb = vsync & ~vsync_d (rising edge of registered vsync). frame_cnt increments on fb and wraps at 2^FCNT_W-1 -> 0.
- Write: cfg_valid & cfg_ready -> shadow[cfg_addr] <= cfg_data. Active outputs are never written directly.
- FSM:
  - IDLE: cfg_ready=1. cfg_apply -> ARMED.
  - ARMED: pending=1, cfg_ready=1 (later writes still merge into the shadow). fb -> COMMIT.
  - COMMIT: ta..td <= shadows, commit=1, cfg_ready=0, pending=1 -> IDLE next cycle.
- Latency: fb at cycle N -> commit high and new ta..td visible at cycle N+1.
- Simultaneous write and fb in ARMED: the write lands in the shadow first and is included in the commit.
- cfg_apply during ARMED: ignored (already armed).
- cfg_apply during COMMIT: ignored, because cfg_ready=0 and a lone apply in COMMIT is also dropped; the host must re-issue it.
- cfg_apply and fb in the same cycle in IDLE: go to ARMED only; commit waits for the next fb.
- Reset mid-ARMED: pending write discarded; shadows revert to INIT.
- No range checking: Ta>Tb is allowed and passes through unchanged.

Optional Feature:
SEG_THR_CTRL_STATS_EN
- Defined: 20-bit counter increments on de & mask (saturates at 2^20-1). On fb: mask_cnt <= counter, counter cleared (a coincident de&mask pixel counts into the new frame), mask_cnt_vld=1 for one cycle.
- Undefined: counter not built; mask_cnt tied to 0, mask_cnt_vld tied to 0.

Decomposition:
- Package seg_pkg holds:
  - threshold address constants THR_TA..THR_TD
  - FSM state encoding (IDLE=0, ARMED=1, COMMIT=2)
  - default threshold constants 90/140/90/126, shared with the bench
  - MASK_CNT_W=20
- One sub-module, seg_edge_det: registered rising-edge detector with ce and rst, reused for the vsync edge.

Test Plan:
1. Reset release, no writes -> ta/tb/tc/td = 90/140/90/126, frame_cnt counts 1,2,3 on successive vsync rises, commit never asserted.
2. Write Ta=100, Td=130, apply mid-frame -> outputs unchanged until vsync rise; one cycle later ta=100, td=130, tb=140, tc=90, commit pulse exactly 1 cycle, pending falls the cycle after.
3. In ARMED, write Tb=150 in the same cycle as vsync rise -> committed tb=150.
4. Apply in the same cycle as vsync rise from IDLE -> no commit that frame; commit at the following vsync rise.
5. Assert rst while ARMED with Tc=70 shadowed -> tc stays 90 after subsequent vsync, no commit.
6. (STATS_EN) Frame with 64x64 de, mask high on 500 pixels -> at next vsync rise mask_cnt=500, mask_cnt_vld pulse; without macro mask_cnt=0 always.
